// File: rtl/dispatch_queue.sv
// Dispatch queue between decode and the reservation stations: a circular buffer whose head
// entries leave in strict age order, gated by ROB slots, free physical registers and RS credits.
module dispatch_queue #(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 128,
    parameter int NBANK     = 4,
    parameter int BANK_SZ   = 8,
    parameter int CNT_W     = 8,
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_valid,
    input  logic [WIDTH*PAYLOAD_W-1:0] in_payload,
    input  logic [WIDTH*BW-1:0]        in_bank,
    input  logic [WIDTH-1:0]           in_uses_rd,
    output logic                       in_ready,
    input  logic [CNT_W-1:0]           rob_free,
    input  logic [CNT_W-1:0]           fl_free,
    input  logic [NBANK*CW-1:0]        credit_ret,
    output logic [WIDTH-1:0]           out_valid,
    output logic [WIDTH*PAYLOAD_W-1:0] out_payload,
    output logic [WIDTH*BW-1:0]        out_bank,
    output logic [WIDTH-1:0]           out_uses_rd,
    output logic [CW-1:0]              out_count,
    output logic [OW-1:0]              occupancy,
    output logic                       credit_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW = CNT_W + 1;

    logic [PAYLOAD_W-1:0] pay_mem_r [DEPTH];
    logic [BW-1:0]        bank_mem_r [DEPTH];
    logic [DEPTH-1:0]     rd_mem_r;
    logic [PW-1:0]        head_r;
    logic [PW-1:0]        tail_r;
    logic [OW-1:0]        occ_r;
    logic [XW-1:0]        credit_r [NBANK];
    logic                 err_r;

    logic                 ready_s;
    logic                 enq_en_s;
    logic [CW-1:0]        enq_cnt_s;
    logic [CW-1:0]        out_cnt_s;
    logic [CW-1:0]        disp_bank_s [NBANK];
    logic [XW-1:0]        credit_sum_s [NBANK];
    logic [NBANK-1:0]     credit_ovf_s;

    // Free space is judged on registered occupancy only; a same-cycle dispatch earns no room.
    assign ready_s   = ((DEPTH - int'(occ_r)) >= WIDTH);
    assign enq_en_s  = ready_s && !flush;
    assign in_ready  = ready_s;
    assign out_count = out_cnt_s;
    assign occupancy = occ_r;
    assign credit_err = err_r;

    // Count the offered lanes; decode always presents them contiguously from lane 0.
    always_comb begin
        enq_cnt_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            enq_cnt_s = enq_cnt_s + CW'(in_valid[i]);
        end
    end

    // Walk the head entries in age order and stop at the first lane that lacks any resource.
    always_comb begin
        int            rd_cnt;
        int            bank_cnt [NBANK];
        logic          blocked;
        logic [PW-1:0] idx;
        out_cnt_s = '0;
        rd_cnt    = 0;
        blocked   = 1'b0;
        idx       = '0;
        for (int b = 0; b < NBANK; b++) begin
            bank_cnt[b] = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            idx = head_r + PW'(i);
            rd_cnt = rd_cnt + int'(rd_mem_r[idx]);
            bank_cnt[bank_mem_r[idx]] = bank_cnt[bank_mem_r[idx]] + 1;
            if (!blocked && !flush && (i < int'(occ_r)) && (i < int'(rob_free)) &&
                (rd_cnt <= int'(fl_free)) &&
                (bank_cnt[bank_mem_r[idx]] <= int'(credit_r[bank_mem_r[idx]]))) begin
                out_cnt_s = CW'(i + 1);
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Present the dispatched prefix and tally how many entries each bank receives.
    always_comb begin
        logic [PW-1:0] idx;
        out_valid   = '0;
        out_payload = '0;
        out_bank    = '0;
        out_uses_rd = '0;
        idx         = '0;
        for (int b = 0; b < NBANK; b++) begin
            disp_bank_s[b] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            idx = head_r + PW'(i);
            if (i < int'(out_cnt_s)) begin
                out_valid[i]                          = 1'b1;
                out_payload[i*PAYLOAD_W +: PAYLOAD_W] = pay_mem_r[idx];
                out_bank[i*BW +: BW]                  = bank_mem_r[idx];
                out_uses_rd[i]                        = rd_mem_r[idx];
                disp_bank_s[bank_mem_r[idx]]          = disp_bank_s[bank_mem_r[idx]] + CW'(1);
            end else begin
                out_valid[i] = 1'b0;
            end
        end
    end

    // Next credit per bank; a return pushing past the bank size is clamped and flagged.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            credit_sum_s[b] = credit_r[b] - XW'(disp_bank_s[b]) + XW'(credit_ret[b*CW +: CW]);
            credit_ovf_s[b] = (credit_sum_s[b] > XW'(BANK_SZ));
        end
    end

    // Queue pointers, occupancy and entry storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r   <= '0;
            tail_r   <= '0;
            occ_r    <= '0;
            rd_mem_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pay_mem_r[k]  <= '0;
                bank_mem_r[k] <= '0;
            end
        end else if (flush) begin
            head_r <= tail_r;
            occ_r  <= '0;
        end else begin
            head_r <= head_r + PW'(out_cnt_s);
            if (enq_en_s) begin
                tail_r <= tail_r + PW'(enq_cnt_s);
                occ_r  <= occ_r + OW'(enq_cnt_s) - OW'(out_cnt_s);
                for (int j = 0; j < WIDTH; j++) begin
                    if (in_valid[j]) begin
                        pay_mem_r[tail_r + PW'(j)]  <= in_payload[j*PAYLOAD_W +: PAYLOAD_W];
                        bank_mem_r[tail_r + PW'(j)] <= in_bank[j*BW +: BW];
                        rd_mem_r[tail_r + PW'(j)]   <= in_uses_rd[j];
                    end
                end
            end else begin
                occ_r <= occ_r - OW'(out_cnt_s);
            end
        end
    end

    // Bank credits and the sticky overflow flag; flush relies on credit_ret for squashed entries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
            for (int b = 0; b < NBANK; b++) begin
                credit_r[b] <= XW'(BANK_SZ);
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (credit_ovf_s[b]) begin
                    credit_r[b] <= XW'(BANK_SZ);
                end else begin
                    credit_r[b] <= credit_sum_s[b];
                end
            end
            if (|credit_ovf_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameter WIDTH, default 3, lanes enqueued/dispatched per cycle (>=1).
REQ-002 Parameter DEPTH, default 8, queue entries; SHALL be a power of two and >= WIDTH.
REQ-003 Parameter PAYLOAD_W, default 128, opaque per-instruction payload bits.
REQ-004 Parameter NBANK, default 4, RS banks (ALU, MULT, BRANCH, MEM); BW = $clog2(NBANK).
REQ-005 Parameter BANK_SZ, default 8, entries per RS bank and reset credit value; CNT_W, default 8, width of free-count inputs.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low: state clears immediately while 0, independent of clock.
REQ-008 flush  in  1  mispredict squash; synchronous.
REQ-009 in_valid  in  WIDTH  lanes offered by decode; contiguous from lane 0.
REQ-010 in_payload  in  WIDTH*PAYLOAD_W  per-lane payload.
REQ-011 in_bank  in  WIDTH*BW  per-lane target RS bank.
REQ-012 in_uses_rd  in  WIDTH  per-lane destination-register flag.
REQ-013 in_ready  out  1  queue accepts the whole offered group this cycle.
REQ-014 rob_free  in  CNT_W  free ROB slots this cycle.
REQ-015 fl_free  in  CNT_W  free physical registers this cycle.
REQ-016 credit_ret  in  NBANK*$clog2(WIDTH+1)  per-bank RS entries released this cycle.
REQ-017 out_valid  out  WIDTH  dispatched lanes, contiguous from lane 0, oldest in lane 0.
REQ-018 out_payload / out_bank / out_uses_rd  out  WIDTH*PAYLOAD_W / WIDTH*BW / WIDTH  head entries in age order.
REQ-019 out_count  out  $clog2(WIDTH+1)  number of lanes dispatched (= popcount(out_valid)).
REQ-020 occupancy  out  $clog2(DEPTH+1)  valid entries held.
REQ-021 credit_err  out  1  sticky: a credit return overflowed BANK_SZ.

Function
REQ-022 Storage: circular buffer, head/tail pointers mod DEPTH; wrap-around SHALL be seamless, age order preserved.
REQ-023 in_ready = (DEPTH - occupancy) >= WIDTH, from registered state only (same-cycle dispatch not credited); all-or-nothing enqueue of popcount(in_valid) entries when in_ready && !flush.
REQ-024 Enqueued entries SHALL not be dispatchable before the next cycle (1-cycle minimum latency).
REQ-025 Lane i (i < WIDTH) is eligible iff i < occupancy, i < rob_free, (in_uses_rd count over lanes 0..i) <= fl_free, and (count of lanes 0..i with bank b) <= credit[b] for its bank b.
REQ-026 out_count = index of first ineligible lane (strict in-order prefix); later eligible lanes SHALL not dispatch.
REQ-027 Dispatched entries leave the queue at the clock edge; head advances by out_count mod DEPTH.
REQ-028 credit[b] next = credit[b] - dispatched_to_b + credit_ret[b], computed at width CNT_W+1; result > BANK_SZ clamps to BANK_SZ and sets credit_err.
REQ-029 Simultaneous enqueue and dispatch in one cycle SHALL both take effect; occupancy next = occupancy + enq - out_count.
REQ-030 flush: out_valid = 0 and out_count = 0 combinationally; enqueue dropped; next cycle occupancy = 0, head = tail.
REQ-031 flush SHALL not alter credits except by credit_ret that cycle (RS returns squashed entries via credit_ret).
REQ-032 Empty queue: out_valid = 0; full queue: in_ready = 0, dispatch unaffected.
REQ-033 out_* lanes with out_valid = 0 SHALL drive 0.

Reset
REQ-034 While reset = 0: occupancy 0, head = tail = 0, out_valid 0, out_count 0, in_ready 1, credit[b] = BANK_SZ all b, credit_err 0.
REQ-035 Reset asserted mid-operation discards all queued entries without emitting them; first dispatch possible the second cycle after release.

Verification (WIDTH=3, DEPTH=8, BANK_SZ=8)
REQ-036 Enqueue 3 ALU, rob_free=fl_free=8 -> next cycle out_count=3, out_valid=3'b111, credit[ALU]=5 after edge.
REQ-037 Queue holds 3 uses_rd lanes, fl_free=1 -> out_count=1; fl_free=0 -> out_count=0, occupancy unchanged.
REQ-038 Lanes bank MULT,ALU,MULT with credit[MULT]=1 -> out_count=2 (lane 2 blocked), lane 2 dispatches next cycle after credit_ret[MULT]=1.
REQ-039 Eight enqueues over 3 cycles with rob_free=0 -> occupancy 6 then in_ready=0; raise rob_free=8 -> FIFO order across pointer wrap verified by payload IDs.
REQ-040 flush with occupancy 5 and enqueue offered -> out_count=0 that cycle, occupancy=0 next cycle; credit_ret[ALU]=1 at credit 8 -> credit stays 8, credit_err=1 until reset.
